// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between ID-stage decode and the hazard scoreboard.
// master drives the decoded instruction and flush; slave returns stall,
// forwarding selects and the stall-cycle counter.
interface hazard_scoreboard_if #(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int CW    = 16
);
    localparam int SW = $clog2(DEPTH + 1);

    logic          IssueValid;
    logic [AW-1:0] IssueRs;
    logic [AW-1:0] IssueRt;
    logic          UsesRs;
    logic          UsesRt;
    logic          IssueWrites;
    logic [AW-1:0] IssueDest;
    logic          IssueIsLoad;
    logic          Flush;
    logic          Stall;
    logic [SW-1:0] FwdSelA;
    logic [SW-1:0] FwdSelB;
    logic [CW-1:0] StallCount;

    modport master (
        output IssueValid, IssueRs, IssueRt, UsesRs, UsesRt,
               IssueWrites, IssueDest, IssueIsLoad, Flush,
        input  Stall, FwdSelA, FwdSelB, StallCount
    );

    modport slave (
        input  IssueValid, IssueRs, IssueRt, UsesRs, UsesRt,
               IssueWrites, IssueDest, IssueIsLoad, Flush,
        output Stall, FwdSelA, FwdSelB, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for the pipelined MIPS core. Tracks the register
// writers in flight for DEPTH stages after ID and resolves each ID-stage
// source to a forwarding select or a stall. Taken branches squash the
// youngest writers; stall cycles are counted with saturation.
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int FORWARD  = 1,
    parameter int FLUSH_N  = 1,
    parameter int CW       = 16
) (
    input logic                Clk,
    input logic                Reset,
    hazard_scoreboard_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic          isLoad;
    } EntryT;

    // entries[0] is the instruction now in EX, entries[DEPTH-1] the oldest.
    EntryT         entries [DEPTH];
    logic [CW-1:0] stallCount;

    logic          hitA, hitB;
    logic          fwdOkA, fwdOkB;
    logic [SW-1:0] idxA, idxB;
    logic          blocked;
    logic          active;
    logic          stallNow;

    // Youngest matching writer per source, and whether its value is ready yet.
    always_comb begin
        // NOTE: every comb output gets a default before the loop so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        hitA   = 1'b0;
        hitB   = 1'b0;
        fwdOkA = 1'b0;
        fwdOkB = 1'b0;
        idxA   = '0;
        idxB   = '0;
        // Walk oldest to youngest so the lowest matching index is the one kept.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries[i].valid && bus.UsesRs && bus.IssueRs != '0 &&
                entries[i].dest == bus.IssueRs) begin
                hitA   = 1'b1;
                idxA   = SW'(i);
                fwdOkA = i >= (entries[i].isLoad ? LOAD_LAT : ALU_LAT);
            end
            if (entries[i].valid && bus.UsesRt && bus.IssueRt != '0 &&
                entries[i].dest == bus.IssueRt) begin
                hitB   = 1'b1;
                idxB   = SW'(i);
                fwdOkB = i >= (entries[i].isLoad ? LOAD_LAT : ALU_LAT);
            end
        end
    end

    // Stall decision: stall-only mode blocks on any match, otherwise only on
    // a value that is not yet forwardable. A flushed or empty slot never stalls.
    always_comb begin
        if (FORWARD != 0) begin
            blocked = (hitA && !fwdOkA) || (hitB && !fwdOkB);
        end else begin
            blocked = hitA || hitB;
        end
        active   = bus.IssueValid && !bus.Flush;
        stallNow = active && blocked;
    end

    assign bus.Stall      = stallNow;
    assign bus.FwdSelA    = (FORWARD != 0 && active && !blocked && hitA) ? idxA + SW'(1) : '0;
    assign bus.FwdSelB    = (FORWARD != 0 && active && !blocked && hitB) ? idxB + SW'(1) : '0;
    assign bus.StallCount = stallCount;

    // Advance the writer pipeline, squash flushed entries, count stall cycles.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            // NOTE: the tracker is a handful of flops, not a RAM, so every entry
            // is reset; only the valid bits matter but clearing all is free.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            stallCount <= '0;
        end else begin
            // NOTE: non-blocking updates let every entry read its neighbour's
            // pre-edge value, which is what makes this a shift register.
            for (int i = DEPTH - 1; i > 0; i--) begin
                entries[i] <= '{
                    valid:  entries[i-1].valid && !(bus.Flush && (i - 1) < FLUSH_N),
                    dest:   entries[i-1].dest,
                    isLoad: entries[i-1].isLoad
                };
            end
            entries[0] <= '{
                valid:  bus.IssueValid && bus.IssueWrites && bus.IssueDest != '0 &&
                        !stallNow && !bus.Flush,
                dest:   bus.IssueDest,
                isLoad: bus.IssueIsLoad
            };
            if (stallNow && stallCount != '1) begin
                stallCount <= stallCount + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one forwarding instance with default
// parameters and one stall-only instance with a 2-bit counter, both driven
// by the same issue stream.
module tb_hazard_scoreboard;
    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.AW(5), .DEPTH(3), .CW(16)) fwdIf ();
    hazard_scoreboard_if #(.AW(5), .DEPTH(3), .CW(2))  stlIf ();

    hazard_scoreboard #(.FORWARD(1), .CW(16)) dutFwd (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (fwdIf.slave)
    );

    hazard_scoreboard #(.FORWARD(0), .CW(2)) dutStl (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (stlIf.slave)
    );

    // Free-running clock, period 10.
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic uRs,
                         input logic [4:0] rt, input logic uRt, input logic wr,
                         input logic [4:0] dest, input logic ld, input logic fl);
        fwdIf.IssueValid = v;   stlIf.IssueValid = v;
        fwdIf.IssueRs = rs;     stlIf.IssueRs = rs;
        fwdIf.UsesRs = uRs;     stlIf.UsesRs = uRs;
        fwdIf.IssueRt = rt;     stlIf.IssueRt = rt;
        fwdIf.UsesRt = uRt;     stlIf.UsesRt = uRt;
        fwdIf.IssueWrites = wr; stlIf.IssueWrites = wr;
        fwdIf.IssueDest = dest; stlIf.IssueDest = dest;
        fwdIf.IssueIsLoad = ld; stlIf.IssueIsLoad = ld;
        fwdIf.Flush = fl;       stlIf.Flush = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock and land 2 time units past the rising edge.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Clk    = 1'b0;
        Reset  = 1'b0;
        idle();
        #12;
        check("reset_stall",  fwdIf.Stall, 0);
        check("reset_fwdA",   fwdIf.FwdSelA, 0);
        check("reset_fwdB",   fwdIf.FwdSelB, 0);
        check("reset_count",  fwdIf.StallCount, 0);
        tick();
        Reset = 1'b1;

        // ALU producer then consumer: forward from EX, no stall.
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0);                 // add $8
        check("alu_prod_stall", fwdIf.Stall, 0);
        tick();
        drive(1, 8, 1, 2, 1, 1, 9, 0, 0);                 // sub $9,$8,$2
        check("alu_fwd_stall", fwdIf.Stall, 0);
        check("alu_fwd_selA",  fwdIf.FwdSelA, 1);
        check("alu_fwd_selB",  fwdIf.FwdSelB, 0);
        tick();

        // Load-use: one stall, then forward from MEM.
        drive(1, 1, 1, 0, 0, 1, 9, 1, 0);                 // lw $9,0($1)
        check("lw_issue_stall", fwdIf.Stall, 0);
        tick();
        drive(1, 3, 1, 9, 1, 1, 10, 0, 0);                // add $10,$3,$9
        check("lu_stall",       fwdIf.Stall, 1);
        check("lu_stall_selB",  fwdIf.FwdSelB, 0);
        check("lu_stall_selA",  fwdIf.FwdSelA, 0);
        tick();
        check("lu_count",       fwdIf.StallCount, 1);
        check("lu_after_stall", fwdIf.Stall, 0);
        check("lu_after_selB",  fwdIf.FwdSelB, 2);
        check("lu_after_selA",  fwdIf.FwdSelA, 0);
        tick();

        // Youngest writer wins.
        drive(1, 0, 0, 0, 0, 1, 10, 0, 0);                // add $10
        tick();
        drive(1, 0, 0, 0, 0, 1, 10, 0, 0);                // or $10
        tick();
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);                // consumer of $10
        check("young_stall", fwdIf.Stall, 0);
        check("young_selA",  fwdIf.FwdSelA, 1);
        tick();
        check("young_count", fwdIf.StallCount, 1);

        // Flush beats a load-use dependence and squashes the load.
        drive(1, 1, 1, 0, 0, 1, 9, 1, 0);                 // lw $9
        tick();
        drive(1, 0, 0, 9, 1, 0, 0, 0, 1);                 // $9 consumer, Flush
        check("flush_stall", fwdIf.Stall, 0);
        check("flush_selB",  fwdIf.FwdSelB, 0);
        tick();
        check("flush_count", fwdIf.StallCount, 1);
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0);                 // $9 consumer again
        check("post_flush_stall", fwdIf.Stall, 0);
        check("post_flush_selB",  fwdIf.FwdSelB, 0);
        tick();

        // Register 0 is never recorded or matched.
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);                 // add $0
        tick();
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0);                 // reader of $0
        check("zero_stall", fwdIf.Stall, 0);
        check("zero_selA",  fwdIf.FwdSelA, 0);
        check("zero_selB",  fwdIf.FwdSelB, 0);
        tick();

        // Asynchronous reset in the middle of a stall.
        drive(1, 1, 1, 0, 0, 1, 9, 1, 0);                 // lw $9
        tick();
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0);                 // $9 consumer
        check("pre_reset_stall", fwdIf.Stall, 1);
        #1;
        Reset = 1'b0;
        #1;
        check("async_reset_stall", fwdIf.Stall, 0);
        check("async_reset_selA",  fwdIf.FwdSelA, 0);
        check("async_reset_selB",  fwdIf.FwdSelB, 0);
        check("async_reset_count", fwdIf.StallCount, 0);
        idle();
        tick();
        tick();
        Reset = 1'b1;
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0);                 // $9 consumer, empty tracker
        check("post_reset_nostall", fwdIf.Stall, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0);                 // add $8
        tick();
        drive(1, 8, 1, 0, 0, 1, 9, 0, 0);                 // consumer of $8
        check("post_reset_stall", fwdIf.Stall, 0);
        check("post_reset_selA",  fwdIf.FwdSelA, 1);
        tick();

        // Stall-only instance: fresh start.
        idle();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("stl_reset_count", stlIf.StallCount, 0);
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0);                 // add $8
        tick();
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);                 // consumer of $8, held
        check("stl_cyc1_stall", stlIf.Stall, 1);
        check("stl_cyc1_selA",  stlIf.FwdSelA, 0);
        tick();
        check("stl_cyc2_stall", stlIf.Stall, 1);
        tick();
        check("stl_cyc3_stall", stlIf.Stall, 1);
        tick();
        check("stl_done_stall", stlIf.Stall, 0);
        check("stl_done_selA",  stlIf.FwdSelA, 0);
        check("stl_done_count", stlIf.StallCount, 3);
        tick();

        // Counter saturation at 2^CW-1 with CW=2.
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0);                 // add $8
        tick();
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);                 // consumer of $8
        check("stl_sat_stall", stlIf.Stall, 1);
        tick();
        check("stl_sat_count", stlIf.StallCount, 3);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the pipelined MIPS core; replaces the stall-only hazard detector. Tracks in-flight register writers for DEPTH stages after ID, and gives the ID-stage instruction operand-forwarding selects or a stall. It also squashes tracked writers on a taken branch/jump and counts stall cycles for performance measurement. It sits beside the ID stage and is driven by controller decode and by the PC-source/flush logic.

## Interface

Parameters:
- AW, 5, register address width (2^AW registers; register 0 hard-wired zero)
- DEPTH, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB)
- ALU_LAT, 0, lowest entry index from which a non-load result is forwardable
- LOAD_LAT, 1, lowest entry index from which a load result is forwardable
- FORWARD, 1, 1 = forwarding enabled; 0 = stall-only mode
- FLUSH_N, 1, number of youngest entries cleared by Flush
- CW, 16, stall-counter width

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- IssueValid  in  1  ID holds a real instruction
- IssueRs, IssueRt  in  AW  ID source register addresses
- UsesRs, UsesRt  in  1  source actually read
- IssueWrites  in  1  instruction writes a register
- IssueDest  in  AW  destination after RegDst/Jal selection
- IssueIsLoad  in  1  destination value comes from data memory
- Flush  in  1  squash ID instruction and entries 0..FLUSH_N-1
- Stall  out  1  hold PC and IF/ID; insert bubble into EX
- FwdSelA, FwdSelB  out  clog2(DEPTH+1)  0 = register file, k = result of entry k-1
- StallCount  out  CW  saturating count of stall cycles

## Operation

- State: DEPTH entries {valid, dest[AW-1:0], isLoad}.
- Match for source s: valid entry with dest == s, source used, s != 0. The youngest match (lowest index i) wins.
- Forwardable: i >= (isLoad ? LOAD_LAT : ALU_LAT).
- FORWARD=1:
  - Any used source whose youngest match is not forwardable -> Stall=1.
  - Otherwise FwdSel = i+1 for a matched source, else 0.
- FORWARD=0:
  - Any match in any entry -> Stall=1.
  - FwdSelA and FwdSelB are always 0.
- Stall, FwdSel are forced to 0 when IssueValid=0 or Flush=1.
- FwdSel is 0 whenever Stall=1.
- Each rising edge:
  - Entries shift: entry i+1 <= entry i; entry DEPTH-1 retires.
  - Entry 0 <= {IssueValid & IssueWrites & IssueDest!=0 & !Stall & !Flush, IssueDest, IssueIsLoad}.
  - On a stall this inserts a bubble at entry 0 while older entries still advance.
- Flush: entries 0..FLUSH_N-1 are invalidated before the shift. Their shifted copies land invalid; entry 0 also loads invalid.
- StallCount increments on every cycle with Stall=1 and saturates at 2^CW-1 (no wrap).
- A destination of register 0 is never recorded. A source of register 0 never matches.

## Timing

- Stall and FwdSel are combinational from the current entries plus the Issue*/Flush inputs, in the same cycle.
- Entries and StallCount update on the rising Clk edge.
- Reset low (asynchronous, any time, including mid-stall): all valid bits 0, StallCount 0. Consequently Stall=0 and FwdSelA=FwdSelB=0 immediately.
- Reset is released synchronously to Clk by the system.
- Load-use with defaults: 1 stall cycle. Then FwdSel = 2, with the load in MEM.
- Back-to-back ALU producer/consumer: 0 stall cycles, FwdSel = 1.
- FORWARD=0, dependence on an instruction just issued: DEPTH stall cycles.
- Simultaneous Flush and a dependence: Flush wins; no stall and no count increment.
- Simultaneous stall and a retiring entry: the retirement still occurs.

## Test plan

- Reset: drive Reset=0 mid-run with entries valid -> immediately Stall=0, FwdSelA/B=0, StallCount=0. After release, an issue of add $8 with a dependent next instruction behaves as from an empty state.
- ALU forward: issue add $8; next cycle issue sub $9,$8,$2 (UsesRs) -> Stall=0, FwdSelA=1, FwdSelB=0.
- Load-use:
  - Issue lw $9; next cycle issue add $10,$3,$9 (UsesRt) -> Stall=1, FwdSelB=0, StallCount=1.
  - Following cycle -> Stall=0, FwdSelB=2.
- Youngest priority: issue add $10, then or $10, then a consumer of $10 in Rs -> FwdSelA=1, not 2.
- Stall-only mode, FORWARD=0: add $8, then a consumer of $8 -> Stall=1 for exactly 3 cycles, then Stall=0 with FwdSelA=0; StallCount=3.
- Flush and $0:
  - Issue lw $9; next cycle Flush=1 while a $9 consumer issues -> Stall=0, StallCount unchanged.
  - Subsequent $9 consumer -> no stall.
  - Issue add $0 followed by a reader of $0 -> FwdSel=0, no stall.
